// File: rtl/updown_step_counter.sv
// updown_step_counter
//   Parametrised up/down step counter with load, hold, and registered status.
//   On each enabled clock the counter loads data_in, steps up by UP_STEP,
//   steps down by DN_STEP, or holds. It also reports carry, borrow, parity,
//   terminal count, and a sticky overflow flag.
//
// Configuration macro:
//   UPDOWN_STEP_COUNTER_SAT_EN - when defined, sat_mode selects saturate (1)
//                                or wrap (0). When undefined, the counter
//                                always wraps and sat_mode is ignored.
//
// Ports:
//   clock       in   single clock, posedge active
//   reset_n     in   synchronous active-low reset
//   en          in   count enable
//   up, down    in   operation select {up,down}:
//                      00 load, 01 down, 10 up, 11 hold
//   data_in     in   [WIDTH] load value
//   limit_in    in   [WIDTH] terminal-count limit value
//   limit_ld    in   load limit_in into the limit register (independent of en)
//   flag_clr    in   clear ovf_sticky (independent of en; a new set wins)
//   sat_mode    in   1 = saturate, 0 = wrap (only used with the macro)
//   count_out   out  [WIDTH] counter value
//   carry_out   out  up-step overflowed on this update
//   borrow_out  out  down-step underflowed on this update
//   parity_out  out  XOR reduction of count_out
//   tc_out      out  count_out equals the limit that was in effect before the edge
//   ovf_sticky  out  latched carry/borrow history
module updown_step_counter #(
    parameter int unsigned WIDTH   = 9,
    parameter int unsigned UP_STEP = 3,
    parameter int unsigned DN_STEP = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] limit_in,
    input  logic             limit_ld,
    input  logic             flag_clr,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count_out,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             parity_out,
    output logic             tc_out,
    output logic             ovf_sticky
);

    typedef logic [WIDTH:0]   ext_t;
    typedef logic [WIDTH-1:0] cnt_t;

    localparam ext_t UP_EXT = ext_t'(UP_STEP);
    localparam ext_t DN_EXT = ext_t'(DN_STEP);

    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] count_nxt;
    logic             carry_nxt;
    logic             borrow_nxt;
    ext_t             sum_c;
    ext_t             diff_c;

    // Both step results are computed one bit wider. The extra top bit is
    // the carry or borrow.
    assign sum_c  = {1'b0, count_out} + UP_EXT;
    assign diff_c = {1'b0, count_out} - DN_EXT;

`ifndef UPDOWN_STEP_COUNTER_SAT_EN
    logic unused_sat_mode;
    assign unused_sat_mode = sat_mode;
`endif

    // Next-count selection and carry/borrow generation
    always_comb begin
        count_nxt  = count_out;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
        if (en) begin
            unique case ({up, down})
                2'b00: count_nxt = data_in;
                2'b01: begin
                    borrow_nxt = diff_c[WIDTH];
                    count_nxt  = diff_c[WIDTH-1:0];
`ifdef UPDOWN_STEP_COUNTER_SAT_EN
                    if (sat_mode && diff_c[WIDTH]) begin
                        count_nxt = '0;
                    end
`endif
                end
                2'b10: begin
                    carry_nxt = sum_c[WIDTH];
                    count_nxt = sum_c[WIDTH-1:0];
`ifdef UPDOWN_STEP_COUNTER_SAT_EN
                    if (sat_mode && sum_c[WIDTH]) begin
                        count_nxt = '1;
                    end
`endif
                end
                default: count_nxt = count_out;
            endcase
        end
    end

    // State and registered status
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_out  <= '0;
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
            parity_out <= 1'b0;
            tc_out     <= 1'b0;
            ovf_sticky <= 1'b0;
            limit_q    <= '1;
        end else begin
            count_out  <= count_nxt;
            carry_out  <= carry_nxt;
            borrow_out <= borrow_nxt;
            parity_out <= ^count_nxt;
            // The comparison uses the limit in effect before this edge.
            tc_out     <= (count_nxt == cnt_t'(limit_q));
            if (limit_ld) begin
                limit_q <= limit_in;
            end
            if (carry_nxt || borrow_nxt) begin
                ovf_sticky <= 1'b1;
            end else if (flag_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule
